// File: rtl/sc_lane_feeder.sv
// Multi-lane scratchpad read server for systolic_array_top.
// Write-first storage, READ_LAT-deep stallable lane pipeline, controller port.
module sc_lane_feeder #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int READ_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 sc_valid_queue,
    input  logic [N*ADDR_WIDTH-1:0]      sc_x_queue,
    input  logic [N*ADDR_WIDTH-1:0]      sc_w_queue,
    input  logic                         stall,
    output logic [N*DATA_WIDTH-1:0]      sc_x_data,
    output logic [N*DATA_WIDTH-1:0]      sc_w_data,
    output logic [N-1:0]                 sc_data_valid,
    input  logic                         ctrl_write_en,
    input  logic                         ctrl_read_en,
    input  logic [ADDR_WIDTH-1:0]        ctrl_addr,
    input  logic [DATA_WIDTH-1:0]        ctrl_wdata,
    output logic [DATA_WIDTH-1:0]        ctrl_rdata,
    output logic                         ctrl_rvalid,
    output logic                         oob_err,
    input  logic                         err_clear,
    output logic [31:0]                  read_count
);

    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic in_rng(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    logic [DW-1:0] mem_q [DEPTH];

    logic                    wr_ok;
    logic [N-1:0][DW-1:0]    x_in;
    logic [N-1:0][DW-1:0]    w_in;
    logic [N-1:0]            lane_bad;
    logic [DW-1:0]           c_rd;
    logic                    oob_new;
    logic [31:0]             pop;

    logic [READ_LAT-1:0][N-1:0][DW-1:0] px_q;
    logic [READ_LAT-1:0][N-1:0][DW-1:0] pw_q;
    logic [READ_LAT-1:0][N-1:0]         pv_q;

    logic [DW-1:0] rdata_q;
    logic          rvalid_q;
    logic          oob_q, oob_d;
    logic [31:0]   cnt_q, cnt_d;

    assign wr_ok = ctrl_write_en && in_rng(ctrl_addr);

    // Reads bypass the array when a write to the same word lands this edge.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [AW-1:0] xa;
        logic [AW-1:0] wa;
        logic [DW-1:0] xr;
        logic [DW-1:0] wr;
        assign xa = sc_x_queue[i*AW +: AW];
        assign wa = sc_w_queue[i*AW +: AW];
        assign xr = !in_rng(xa) ? '0 :
                    (wr_ok && ctrl_addr == xa) ? ctrl_wdata :
                    mem_q[xa[IW-1:0]];
        assign wr = !in_rng(wa) ? '0 :
                    (wr_ok && ctrl_addr == wa) ? ctrl_wdata :
                    mem_q[wa[IW-1:0]];
        assign x_in[i]     = sc_valid_queue[i] ? xr : '0;
        assign w_in[i]     = sc_valid_queue[i] ? wr : '0;
        assign lane_bad[i] = !in_rng(xa) || !in_rng(wa);
    end

    assign c_rd = !in_rng(ctrl_addr) ? '0 :
                  ctrl_write_en ? ctrl_wdata :
                  mem_q[ctrl_addr[IW-1:0]];

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + 32'(sc_valid_queue[i]);
        end
    end

    always_comb begin
        oob_new = (!stall && |(sc_valid_queue & lane_bad)) ||
                  ((ctrl_write_en || ctrl_read_en) && !in_rng(ctrl_addr));
        oob_d   = oob_q;
        if (oob_new) begin
            oob_d = 1'b1;
        end else if (err_clear) begin
            oob_d = 1'b0;
        end
        cnt_d = stall ? cnt_q : cnt_q + (pop << 1);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[ctrl_addr[IW-1:0]] <= ctrl_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q     <= '0;
            pw_q     <= '0;
            pv_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            oob_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (!stall) begin
                px_q[0] <= x_in;
                pw_q[0] <= w_in;
                pv_q[0] <= sc_valid_queue;
                for (int s = 1; s < READ_LAT; s++) begin
                    px_q[s] <= px_q[s-1];
                    pw_q[s] <= pw_q[s-1];
                    pv_q[s] <= pv_q[s-1];
                end
            end
            rdata_q  <= ctrl_read_en ? c_rd : '0;
            rvalid_q <= ctrl_read_en;
            oob_q    <= oob_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sc_x_data     = px_q[READ_LAT-1];
    assign sc_w_data     = pw_q[READ_LAT-1];
    assign sc_data_valid = pv_q[READ_LAT-1];
    assign ctrl_rdata    = rdata_q;
    assign ctrl_rvalid   = rvalid_q;
    assign oob_err       = oob_q;
    assign read_count    = cnt_q;

endmodule

// File: tb/tb_sc_lane_feeder.sv
// Directed bench for sc_lane_feeder: vector table on a READ_LAT=1 / DEPTH=1000
// instance plus stall and reset sequences on READ_LAT=3 and READ_LAT=2 instances.
module tb_sc_lane_feeder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  vld;
    logic [39:0] xq, wq;
    logic        stall, we, re, clr;
    logic [9:0]  ca;
    logic [31:0] cd;

    logic [127:0] m_x, m_w, a_x, a_w, b_x, b_w;
    logic [3:0]   m_v, a_v, b_v;
    logic [31:0]  m_rd, a_rd, b_rd, m_cnt, a_cnt, b_cnt;
    logic         m_rv, a_rv, b_rv, m_oob, a_oob, b_oob;

    int n_cmp = 0;
    int n_err = 0;

    sc_lane_feeder #(.DEPTH(1000), .READ_LAT(1)) u_m (
        .clk(clk), .rst(rst), .sc_valid_queue(vld), .sc_x_queue(xq),
        .sc_w_queue(wq), .stall(stall), .sc_x_data(m_x), .sc_w_data(m_w),
        .sc_data_valid(m_v), .ctrl_write_en(we), .ctrl_read_en(re),
        .ctrl_addr(ca), .ctrl_wdata(cd), .ctrl_rdata(m_rd),
        .ctrl_rvalid(m_rv), .oob_err(m_oob), .err_clear(clr),
        .read_count(m_cnt));

    sc_lane_feeder #(.DEPTH(1024), .READ_LAT(3)) u_a (
        .clk(clk), .rst(rst), .sc_valid_queue(vld), .sc_x_queue(xq),
        .sc_w_queue(wq), .stall(stall), .sc_x_data(a_x), .sc_w_data(a_w),
        .sc_data_valid(a_v), .ctrl_write_en(we), .ctrl_read_en(re),
        .ctrl_addr(ca), .ctrl_wdata(cd), .ctrl_rdata(a_rd),
        .ctrl_rvalid(a_rv), .oob_err(a_oob), .err_clear(clr),
        .read_count(a_cnt));

    sc_lane_feeder #(.DEPTH(1024), .READ_LAT(2)) u_b (
        .clk(clk), .rst(rst), .sc_valid_queue(vld), .sc_x_queue(xq),
        .sc_w_queue(wq), .stall(stall), .sc_x_data(b_x), .sc_w_data(b_w),
        .sc_data_valid(b_v), .ctrl_write_en(we), .ctrl_read_en(re),
        .ctrl_addr(ca), .ctrl_wdata(cd), .ctrl_rdata(b_rd),
        .ctrl_rvalid(b_rv), .oob_err(b_oob), .err_clear(clr),
        .read_count(b_cnt));

    typedef struct {
        string        nm;
        logic [3:0]   vld;
        logic [39:0]  xa, wa;
        logic         we, re;
        logic [9:0]   ca;
        logic [31:0]  cd;
        logic         clr;
        logic [127:0] ex, ew;
        logic [3:0]   ev;
        logic [31:0]  ecnt, erd;
        logic         erv, eoob;
    } vec_t;

    vec_t tv[$];

    function automatic logic [39:0] a4(input int a0, a1, a2, a3);
        return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    endfunction

    function automatic logic [127:0] d4(input logic [31:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic vec_t mk(
        input string nm, input logic [3:0] v, input logic [39:0] xa, wa,
        input logic w, r, input int a, input logic [31:0] d, input logic c,
        input logic [127:0] ex, ew, input logic [3:0] ev,
        input logic [31:0] ecnt, erd, input logic erv, eoob);
        vec_t t;
        t.nm = nm; t.vld = v; t.xa = xa; t.wa = wa; t.we = w; t.re = r;
        t.ca = 10'(a); t.cd = d; t.clr = c; t.ex = ex; t.ew = ew;
        t.ev = ev; t.ecnt = ecnt; t.erd = erd; t.erv = erv; t.eoob = eoob;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        vld = '0; xq = '0; wq = '0; stall = 1'b0;
        we = 1'b0; re = 1'b0; ca = '0; cd = '0; clr = 1'b0;
    endtask

    initial begin
        logic [127:0] z;
        z = '0;
        tv.push_back(mk("all_lanes", 4'hF, a4(0,1,2,3), a4(16,17,18,19),
            0, 0, 0, 0, 0, d4(32'h100,32'h101,32'h102,32'h103),
            d4(32'h110,32'h111,32'h112,32'h113), 4'hF, 8, 0, 0, 0));
        tv.push_back(mk("mask1010", 4'hA, a4(4,5,6,7), a4(20,21,22,23),
            0, 0, 0, 0, 0, d4(0,32'h105,0,32'h107),
            d4(0,32'h115,0,32'h117), 4'hA, 12, 0, 0, 0));
        tv.push_back(mk("ctrl_rd", 4'h0, 0, 0, 0, 1, 10, 0, 0,
            z, z, 4'h0, 12, 32'h10A, 1, 0));
        tv.push_back(mk("wr_first", 4'h4, a4(0,0,5,0), a4(0,0,8,0),
            1, 1, 5, 32'hDEADBEEF, 0, d4(0,0,32'hDEADBEEF,0),
            d4(0,0,32'h108,0), 4'h4, 14, 32'hDEADBEEF, 1, 0));
        tv.push_back(mk("dup_addr", 4'hF, a4(5,5,5,5), a4(0,31,5,1),
            0, 0, 0, 0, 0, {4{32'hDEADBEEF}},
            d4(32'h100,32'h11F,32'hDEADBEEF,32'h101), 4'hF, 22, 0, 0, 0));
        tv.push_back(mk("oob_rd", 4'h1, a4(1000,0,0,0), a4(3,0,0,0),
            0, 0, 0, 0, 0, z, d4(32'h103,0,0,0), 4'h1, 24, 0, 0, 1));
        tv.push_back(mk("clr_vs_oob", 4'h1, a4(1023,0,0,0), a4(0,0,0,0),
            0, 0, 0, 0, 1, z, d4(32'h100,0,0,0), 4'h1, 26, 0, 0, 1));
        tv.push_back(mk("clr", 4'h0, 0, 0, 0, 0, 0, 0, 1,
            z, z, 4'h0, 26, 0, 0, 0));
        tv.push_back(mk("last_word", 4'h8, a4(0,0,0,999), a4(0,0,0,999),
            1, 0, 999, 32'hCAFE, 0, d4(0,0,0,32'hCAFE),
            d4(0,0,0,32'hCAFE), 4'h8, 28, 0, 0, 0));
        tv.push_back(mk("oob_wr", 4'h0, 0, 0, 1, 0, 1000, 32'h123, 0,
            z, z, 4'h0, 28, 0, 0, 1));
        tv.push_back(mk("oob_rd_clr", 4'h0, 0, 0, 0, 1, 1000, 0, 1,
            z, z, 4'h0, 28, 0, 1, 1));
        tv.push_back(mk("clr2", 4'h0, 0, 0, 0, 0, 0, 0, 1,
            z, z, 4'h0, 28, 0, 0, 0));
        tv.push_back(mk("rd_999", 4'h0, 0, 0, 0, 1, 999, 0, 0,
            z, z, 4'h0, 28, 32'hCAFE, 1, 0));

        idle();
        rst = 1'b1;
        #1;
        chk("rst_m_x", m_x, 0);   chk("rst_m_w", m_w, 0);
        chk("rst_m_v", m_v, 0);   chk("rst_m_rd", m_rd, 0);
        chk("rst_m_cnt", m_cnt, 0);
        chk("rst_m_rv", m_rv, 0); chk("rst_m_oob", m_oob, 0);
        chk("rst_a_x", a_x, 0);   chk("rst_a_w", a_w, 0);
        chk("rst_a_v", a_v, 0);   chk("rst_a_rd", a_rd, 0);
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_a_rv", a_rv, 0); chk("rst_a_oob", a_oob, 0);
        chk("rst_b_x", b_x, 0);   chk("rst_b_w", b_w, 0);
        chk("rst_b_v", b_v, 0);   chk("rst_b_rd", b_rd, 0);
        chk("rst_b_cnt", b_cnt, 0);
        chk("rst_b_rv", b_rv, 0); chk("rst_b_oob", b_oob, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            we = 1'b1; ca = 10'(k); cd = 32'(k + 32'h100);
        end
        @(negedge clk);
        idle();

        foreach (tv[i]) begin
            @(negedge clk);
            vld = tv[i].vld; xq = tv[i].xa; wq = tv[i].wa; stall = 1'b0;
            we = tv[i].we; re = tv[i].re; ca = tv[i].ca; cd = tv[i].cd;
            clr = tv[i].clr;
            @(posedge clk);
            #1;
            chk({tv[i].nm, ".x"}, m_x, tv[i].ex);
            chk({tv[i].nm, ".w"}, m_w, tv[i].ew);
            chk({tv[i].nm, ".v"}, m_v, tv[i].ev);
            chk({tv[i].nm, ".cnt"}, m_cnt, tv[i].ecnt);
            chk({tv[i].nm, ".rd"}, m_rd, tv[i].erd);
            chk({tv[i].nm, ".rv"}, m_rv, tv[i].erv);
            chk({tv[i].nm, ".oob"}, m_oob, tv[i].eoob);
        end

        // Six requests on cycles 0,1,4..7 with stall on cycles 2,3.
        begin
            int j = 0;
            int mj = -1;
            int ecnt = 28;
            for (int k = 0; k <= 10; k++) begin
                @(negedge clk);
                idle();
                if (k == 2 || k == 3) begin
                    stall = 1'b1; vld = 4'hF;
                end else if (j < 6) begin
                    vld = 4'hF;
                    xq = {4{10'(8 + j)}};
                    wq = {4{10'(24 + j)}};
                    mj = j; j++; ecnt += 8;
                end else begin
                    mj = -1;
                end
                @(posedge clk);
                #1;
                if (k >= 4 && k <= 9) begin
                    chk("lat3_x", a_x, {4{32'(32'h108 + k - 4)}});
                    chk("lat3_w", a_w, {4{32'(32'h118 + k - 4)}});
                    chk("lat3_v", a_v, 4'hF);
                end else begin
                    chk("lat3_x0", a_x, 0);
                    chk("lat3_v0", a_v, 0);
                end
                chk("stall_m_x", m_x, mj < 0 ? 128'h0 : {4{32'(32'h108 + mj)}});
                chk("stall_m_v", m_v, mj < 0 ? 4'h0 : 4'hF);
                chk("stall_cnt", m_cnt, 32'(ecnt));
            end
        end

        // Reset with two requests in flight on the READ_LAT=2 instance.
        @(negedge clk);
        vld = 4'hF; xq = {4{10'd8}}; wq = {4{10'd24}};
        @(negedge clk);
        xq = {4{10'd9}}; wq = {4{10'd25}};
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle();
        #1;
        chk("rst2_b_v", b_v, 0);
        chk("rst2_b_x", b_x, 0);
        chk("rst2_b_cnt", b_cnt, 0);
        chk("rst2_m_cnt", m_cnt, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("post_rst_v", b_v, 0);
        end
        @(negedge clk);
        vld = 4'hF; xq = {4{10'd8}}; wq = {4{10'd24}};
        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        chk("mem_keep_x", b_x, {4{32'h108}});
        chk("mem_keep_w", b_w, {4{32'h118}});
        chk("mem_keep_v", b_v, 4'hF);
        chk("mem_keep_cnt", b_cnt, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
